seq_divider: RTL and testbench



---
 rtl/seq_divider.sv | 131 +++++++++++++
 tb/tb_seq_divider.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// seq_divider: iterative 32-bit radix-2 restoring divider with RV32M
// div/divu/rem/remu semantics. One request in flight at a time; the result
// appears with a one-cycle `completed` pulse exactly 33 cycles after accept.
//
// Handshake: `enable` is a single-cycle request strobe that is honoured only
// while the FSM is IDLE (a request in RUN or FIX is dropped, not queued);
// operands and `is_signed` are captured on the accepting edge. `completed`
// is high for exactly one cycle per accepted request, with `q`/`r` valid in
// that cycle; `q`/`r` then hold until the next completion or reset.
module seq_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        is_signed,
  input  logic [31:0] s,
  input  logic [31:0] t,
  output logic        completed,
  output logic [31:0] q,
  output logic [31:0] r
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  // FSM state, kept as a named signal so checkers can bind to it.
  state_t      state;

  logic [5:0]  cnt;       // completed RUN steps
  logic [32:0] rem;       // partial remainder
  logic [31:0] dvd;       // dividend magnitude, shifts out as quotient shifts in
  logic [31:0] dvs;       // divisor magnitude
  logic [31:0] raw_s;     // untouched operands for the special-case rules
  logic [31:0] raw_t;
  logic        sgn_mode;
  logic        sign_s;
  logic        sign_t;

  logic [31:0] s_mag;
  logic [31:0] t_mag;
  logic [33:0] shifted;
  logic [33:0] trial;
  logic        fits;
  logic [31:0] fix_q;
  logic [31:0] fix_r;

  // Operand magnitudes at accept; 0x80000000 maps to itself and is then
  // handled as an unsigned value by the datapath.
  always_comb begin
    s_mag = s;
    t_mag = t;
    if (is_signed && s[31]) s_mag = 32'd0 - s;
    if (is_signed && t[31]) t_mag = 32'd0 - t;
  end

  // One restoring step: shift in the next dividend bit and trial-subtract.
  always_comb begin
    shifted = {rem, dvd[31]};
    trial   = shifted - {2'b00, dvs};
    fits    = ~trial[33];
  end

  // Final sign correction and RV32M special cases, first match wins.
  always_comb begin
    fix_q = dvd;
    fix_r = rem[31:0];
    if (raw_t == 32'd0) begin
      fix_q = 32'hFFFF_FFFF;
      fix_r = raw_s;
    end else if (sgn_mode && raw_s == 32'h8000_0000 && raw_t == 32'hFFFF_FFFF) begin
      fix_q = 32'h8000_0000;
      fix_r = 32'd0;
    end else if (sgn_mode) begin
      if (sign_s != sign_t) fix_q = 32'd0 - dvd;
      if (sign_s)           fix_r = 32'd0 - rem[31:0];
    end
  end

  // FSM and datapath registers; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      completed <= 1'b0;
      q         <= 32'd0;
      r         <= 32'd0;
      cnt       <= 6'd0;
      rem       <= 33'd0;
      dvd       <= 32'd0;
      dvs       <= 32'd0;
      raw_s     <= 32'd0;
      raw_t     <= 32'd0;
      sgn_mode  <= 1'b0;
      sign_s    <= 1'b0;
      sign_t    <= 1'b0;
    end else begin
      completed <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            sgn_mode <= is_signed;
            sign_s   <= s[31];
            sign_t   <= t[31];
            raw_s    <= s;
            raw_t    <= t;
            dvd      <= s_mag;
            dvs      <= t_mag;
            rem      <= 33'd0;
            cnt      <= 6'd0;
            state    <= RUN;
          end
        end
        RUN: begin
          rem <= fits ? trial[32:0] : shifted[32:0];
          dvd <= {dvd[30:0], fits};
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) state <= FIX;
        end
        FIX: begin
          q         <= fix_q;
          r         <= fix_r;
          completed <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed vectors for seq_divider with hand-computed
// quotient/remainder values, latency checks and protocol corner cases.
module tb_seq_divider;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        is_signed;
  logic [31:0] s;
  logic [31:0] t;
  logic        completed;
  logic [31:0] q;
  logic [31:0] r;

  int n_cmp;
  int n_err;
  logic [31:0] exp_q[$];

  seq_divider dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .is_signed (is_signed),
    .s         (s),
    .t         (t),
    .completed (completed),
    .q         (q),
    .r         (r)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a request and let the next edge accept it; inputs move #1 after
  // an edge. With hold=1 `enable` stays high into RUN.
  task automatic start_op(input logic sg, input logic [31:0] a, input logic [31:0] b,
                          input logic hold);
    is_signed = sg;
    s         = a;
    t         = b;
    enable    = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) enable = 1'b0;
    check("cmpl_low_at_accept", {31'd0, completed}, 32'd0);
  endtask

  // Wait for completion (bounded), then check latency and result.
  task automatic wait_done(input string tag, input logic [31:0] eq, input logic [31:0] er,
                           input logic hold);
    int lat;
    lat = 0;
    exp_q.push_back(eq);
    exp_q.push_back(er);
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (hold && n < 25) begin
        s         = $urandom;
        t         = $urandom;
        is_signed = 1'($urandom_range(0, 1));
      end else begin
        enable = 1'b0;
      end
      if (completed) begin
        lat = n;
        break;
      end
    end
    check({tag, "_lat"}, lat, 32'd33);
    check({tag, "_q"}, q, exp_q.pop_front());
    check({tag, "_r"}, r, exp_q.pop_front());
  endtask

  task automatic expect_low(input string tag);
    @(posedge clk);
    #1;
    check({tag, "_cmpl_drop"}, {31'd0, completed}, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic sg, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er);
    start_op(sg, a, b, 1'b0);
    wait_done(tag, eq, er, 1'b0);
    expect_low(tag);
  endtask

  initial begin
    int pulses;
    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b1;
    enable    = 1'b0;
    is_signed = 1'b0;
    s         = 32'd0;
    t         = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmpl", {31'd0, completed}, 32'd0);
    check("rst_q", q, 32'd0);
    check("rst_r", r, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic arithmetic
    run_op("udiv_100_7",   1'b0, 32'd100,        32'd7,          32'd14,         32'd2);
    run_op("sdiv_m7_2",    1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF);
    run_op("sdiv_7_m2",    1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1);
    run_op("sdiv_m8_m3",   1'b1, 32'hFFFF_FFF8,  32'hFFFF_FFFD,  32'd2,          32'hFFFF_FFFE);

    // Divide by zero and overflow
    run_op("sdiv_by0",     1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB);
    run_op("udiv_by0",     1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5);
    run_op("sdiv_ovf",     1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0);
    run_op("udiv_ovfops",  1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000);

    // enable held with changing operands during RUN
    start_op(1'b0, 32'd1000, 32'd33, 1'b1);
    wait_done("hold_en", 32'd30, 32'd10, 1'b1);
    expect_low("hold_en");

    // Reset at step 10 aborts the request
    start_op(1'b0, 32'd1234, 32'd5, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_q", q, 32'd0);
    check("abort_r", r, 32'd0);
    pulses = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (completed) pulses++;
    end
    check("abort_no_cmpl", pulses, 32'd0);

    run_op("udiv_after_rst", 1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF);

    // New request in the completed cycle is accepted
    start_op(1'b1, 32'hFFFF_FF9C, 32'd7, 1'b0);
    wait_done("b2b_first", 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
    start_op(1'b0, 32'hDEAD_BEEF, 32'd1, 1'b0);
    wait_done("b2b_second", 32'hDEAD_BEEF, 32'd0, 1'b0);
    expect_low("b2b_second");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
